// File: rtl/ws2812_frame_scheduler.sv
// ws2812_frame_scheduler: paces WS2812 frame launches and arbitrates two requesters.
// Optional feature macro: GLOBAL_BRIGHTNESS_EN (scale every channel at latch time).
module ws2812_frame_scheduler #(
   parameter int LED_COUNT    = 8,
   parameter int CLK_HZ       = 50000000,
   parameter int FRAME_HZ     = 60,
   parameter int BUSY_TIMEOUT = 2000000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_a,
   input  logic [LED_COUNT*24-1:0] data_a,
   input  logic                    req_b,
   input  logic [LED_COUNT*24-1:0] data_b,
   input  logic [7:0]              brightness,
   output logic                    ack_a,
   output logic                    ack_b,
   output logic                    owner,
   output logic [LED_COUNT*24-1:0] drv_data,
   output logic                    drv_start,
   input  logic                    drv_busy,
   output logic                    frame_tick,
   output logic                    timeout_err
);

   localparam int FW     = LED_COUNT * 24;
   localparam int PERIOD = CLK_HZ / FRAME_HZ;
   localparam int PW     = (PERIOD > 2) ? $clog2(PERIOD) : 1;
   localparam int TW     = (BUSY_TIMEOUT > 8) ? $clog2(BUSY_TIMEOUT) : 3;

   localparam logic [PW-1:0] P_LAST = PW'(PERIOD - 1);
   localparam logic [TW-1:0] T_LAST = TW'(BUSY_TIMEOUT - 1);
   localparam logic [TW-1:0] B_LAST = TW'(3);

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [PW-1:0] pcnt;
   logic [TW-1:0] tcnt;
   logic          pending;
   logic          grant;
   logic          grant_b;
   logic          abort;
   logic [FW-1:0] frame_sel;
   logic [FW-1:0] frame_lat;

   // free-running frame period counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pcnt <= '0;
      else if (pcnt == P_LAST)
         pcnt <= '0;
      else
         pcnt <= pcnt + PW'(1);
   end

   assign frame_tick = (pcnt == '0) && !reset;

   // round-robin pick: a lone requester wins, a tie goes away from owner
   assign grant_b   = req_b && (!req_a || !owner);
   assign grant     = (state == IDLE) && pending && (req_a || req_b);
   assign ack_a     = grant && !grant_b;
   assign ack_b     = grant && grant_b;
   assign frame_sel = grant_b ? data_b : data_a;
   assign drv_start = (state == START);

`ifdef GLOBAL_BRIGHTNESS_EN
   function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
      logic [15:0] p;
      p = {8'd0, c} * ({8'd0, b} + 16'd1);
      return p[15:8];
   endfunction

   // scale each 8-bit channel by (brightness+1)/256 on its way into the shadow
   always_comb begin
      frame_lat = frame_sel;
      for (int i = 0; i < LED_COUNT * 3; i++)
         frame_lat[i*8 +: 8] = scale(frame_sel[i*8 +: 8], brightness);
   end
`else
   logic [7:0] unused_brightness;
   assign unused_brightness = brightness;
   assign frame_lat         = frame_sel;
`endif

   // next-state logic with driver handshake timeouts
   always_comb begin
      state_nx = state;
      abort    = 1'b0;
      unique case (state)
         IDLE: begin
            if (grant)
               state_nx = START;
         end
         START: begin
            state_nx = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (drv_busy) begin
               state_nx = WAIT_DONE;
            end else if (tcnt == B_LAST) begin
               state_nx = IDLE;
               abort    = 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!drv_busy) begin
               state_nx = IDLE;
            end else if (tcnt == T_LAST) begin
               state_nx = IDLE;
               abort    = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // state register, per-state wait counter and sticky timeout flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         tcnt        <= '0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_nx;
         if (state_nx != state)
            tcnt <= '0;
         else if (state == WAIT_BUSY || state == WAIT_DONE)
            tcnt <= tcnt + TW'(1);
         if (abort)
            timeout_err <= 1'b1;
      end
   end

   // one launch slot per tick; a tick landing on a grant opens a new slot
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pending <= 1'b0;
      else if (pcnt == '0)
         pending <= 1'b1;
      else if (grant)
         pending <= 1'b0;
   end

   // shadow frame and owner only move on a grant
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drv_data <= '0;
         owner    <= 1'b1;
      end else if (grant) begin
         drv_data <= frame_lat;
         owner    <= grant_b;
      end
   end

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// tb_ws2812_frame_scheduler: randomized scoreboard bench for the frame scheduler.
// Small clock/period so several frame slots fit in a short run.
module tb_ws2812_frame_scheduler;

   localparam int LEDS   = 2;
   localparam int FW     = LEDS * 24;
   localparam int PER    = 100;
   localparam int BT     = 120;
   localparam int INF    = 32'h7fffffff;

   typedef struct {
      int            cyc;
      logic          who;
      logic [FW-1:0] data;
   } exp_t;

   logic          clk;
   logic          reset;
   logic          req_a;
   logic          req_b;
   logic [FW-1:0] data_a;
   logic [FW-1:0] data_b;
   logic [7:0]    brightness;
   logic          ack_a;
   logic          ack_b;
   logic          owner;
   logic [FW-1:0] drv_data;
   logic          drv_start;
   logic          drv_busy;
   logic          frame_tick;
   logic          timeout_err;

   int   total = 0;
   int   bad = 0;
   int   c = 0;
   int   n_starts = 0;
   int   drv_mode = 0;
   int   bcnt = 0;

   exp_t qa[$];
   exp_t qs[$];

   ws2812_frame_scheduler #(
      .LED_COUNT(LEDS),
      .CLK_HZ(1000),
      .FRAME_HZ(10),
      .BUSY_TIMEOUT(BT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req_a(req_a),
      .data_a(data_a),
      .req_b(req_b),
      .data_b(data_b),
      .brightness(brightness),
      .ack_a(ack_a),
      .ack_b(ack_b),
      .owner(owner),
      .drv_data(drv_data),
      .drv_start(drv_start),
      .drv_busy(drv_busy),
      .frame_tick(frame_tick),
      .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver model: mode 0 busy 50 cycles, 1 never busy, 2 busy past timeout
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         drv_busy <= 1'b0;
         bcnt     <= 0;
      end else if (drv_start) begin
         if (drv_mode == 0) begin
            drv_busy <= 1'b1;
            bcnt     <= 50;
         end else if (drv_mode == 2) begin
            drv_busy <= 1'b1;
            bcnt     <= BT + 10;
         end
      end else if (bcnt > 0) begin
         bcnt     <= bcnt - 1;
         drv_busy <= (bcnt > 1);
      end
   end

   function automatic logic [FW-1:0] expect_frame(input logic [FW-1:0] d,
                                                  input logic [7:0] br);
`ifdef GLOBAL_BRIGHTNESS_EN
      logic [FW-1:0] r;
      for (int i = 0; i < FW / 8; i++)
         r[i*8 +: 8] = 8'((int'(d[i*8 +: 8]) * (int'(br) + 1)) / 256);
      return r;
`else
      logic [7:0] unused_br;
      unused_br = br;
      return d;
`endif
   endfunction

   function automatic logic [FW-1:0] rand_frame();
      logic [63:0] t;
      t = {$urandom, $urandom};
      return t[FW-1:0];
   endfunction

   // reference model: slot/free-time bookkeeping, pushes expected grants
   int   pend_m;
   logic own_m;
   int   free_at;
   int   te_at;
   always @(negedge clk) begin
      exp_t e;
      logic win;
      if (reset) begin
         c       = 0;
         pend_m  = 0;
         own_m   = 1'b1;
         free_at = 0;
         te_at   = INF;
         qa.delete();
         qs.delete();
      end else begin
         total++;
         if (frame_tick !== (c % PER == 0)) begin
            bad++;
            $display("FAIL frame_tick cyc=%0d got=%b want=%b",
                     c, frame_tick, (c % PER == 0));
         end
         total++;
         if (timeout_err !== (c >= te_at)) begin
            bad++;
            $display("FAIL timeout_err cyc=%0d got=%b want=%b",
                     c, timeout_err, (c >= te_at));
         end
         if (pend_m != 0 && c >= free_at && (req_a || req_b)) begin
            win    = (req_a && req_b) ? !own_m : req_b;
            e.cyc  = c;
            e.who  = win;
            e.data = expect_frame(win ? data_b : data_a, brightness);
            qa.push_back(e);
            e.cyc  = c + 1;
            qs.push_back(e);
            own_m  = win;
            pend_m = 0;
            if (drv_mode == 0) begin
               free_at = c + 53;
            end else if (drv_mode == 1) begin
               free_at = c + 6;
               if (c + 6 < te_at) te_at = c + 6;
            end else begin
               free_at = c + 3 + BT;
               if (c + 3 + BT < te_at) te_at = c + 3 + BT;
            end
         end
         if (c % PER == 0)
            pend_m = 1;
         c++;
      end
   end

   // monitor: pops the scoreboard whenever the DUT acks or starts
   always begin
      exp_t e;
      int   now;
      @(negedge clk);
      #1;
      if (!reset) begin
         now = c - 1;
         while (qa.size() > 0 && qa[0].cyc < now) begin
            e = qa.pop_front();
            total++;
            bad++;
            $display("FAIL ack_missing want_cyc=%0d got_none", e.cyc);
         end
         while (qs.size() > 0 && qs[0].cyc < now) begin
            e = qs.pop_front();
            total++;
            bad++;
            $display("FAIL start_missing want_cyc=%0d got_none", e.cyc);
         end
         if (ack_a || ack_b) begin
            total++;
            if (qa.size() == 0) begin
               bad++;
               $display("FAIL ack_extra cyc=%0d got a=%b b=%b want none",
                        now, ack_a, ack_b);
            end else begin
               e = qa.pop_front();
               if (e.cyc != now || ack_b !== e.who || ack_a === ack_b) begin
                  bad++;
                  $display("FAIL ack cyc=%0d got a=%b b=%b want cyc=%0d who=%0d",
                           now, ack_a, ack_b, e.cyc, e.who);
               end
            end
         end
         if (drv_start) begin
            n_starts++;
            total++;
            if (qs.size() == 0) begin
               bad++;
               $display("FAIL start_extra cyc=%0d got start want none", now);
            end else begin
               e = qs.pop_front();
               if (e.cyc != now || drv_data !== e.data || owner !== e.who) begin
                  bad++;
                  $display("FAIL start cyc=%0d got data=%h own=%b want cyc=%0d data=%h own=%b",
                           now, drv_data, owner, e.cyc, e.data, e.who);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // n cycles of requester behaviour; drop on ack unless holding
   task automatic run(input int n, input bit hold, input int rnd);
      logic ga;
      logic gb;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ga = ack_a;
         gb = ack_b;
         @(posedge clk);
         #1;
         if (!hold) begin
            if (ga) req_a = 1'b0;
            if (gb) req_b = 1'b0;
         end
         if (rnd != 0) begin
            brightness = 8'($urandom);
            if (!req_a && $urandom_range(rnd - 1, 0) == 0) begin
               req_a  = 1'b1;
               data_a = rand_frame();
            end
            if (!req_b && $urandom_range(rnd - 1, 0) == 0) begin
               req_b  = 1'b1;
               data_b = rand_frame();
            end
         end
      end
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_ack_a"}, 64'(ack_a), 64'd0);
      chk({tag, "_ack_b"}, 64'(ack_b), 64'd0);
      chk({tag, "_start"}, 64'(drv_start), 64'd0);
      chk({tag, "_tick"}, 64'(frame_tick), 64'd0);
      chk({tag, "_terr"}, 64'(timeout_err), 64'd0);
      chk({tag, "_data"}, 64'(drv_data), 64'd0);
      chk({tag, "_owner"}, 64'(owner), 64'd1);
   endtask

   initial begin
      int s0;
      reset      = 1'b1;
      req_a      = 1'b0;
      req_b      = 1'b0;
      data_a     = '0;
      data_b     = '0;
      brightness = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      reset_checks("rst");

      req_a  = 1'b1;
      data_a = 48'h00FF00_0000FF;
      #1;
      reset  = 1'b0;
      run(60, 1'b0, 0);

      req_a  = 1'b1;
      req_b  = 1'b1;
      data_a = 48'h123456_789ABC;
      data_b = 48'hFEDCBA_987654;
      run(250, 1'b1, 0);
      req_a  = 1'b0;
      req_b  = 1'b0;

      run(250, 1'b0, 0);
      req_b  = 1'b1;
      data_b = rand_frame();
      run(150, 1'b1, 0);
      req_b  = 1'b0;

      drv_mode = 1;
      req_a    = 1'b1;
      data_a   = rand_frame();
      run(50, 1'b0, 0);
      drv_mode = 0;
      req_a    = 1'b1;
      data_a   = rand_frame();
      run(120, 1'b0, 0);

      drv_mode = 2;
      req_b    = 1'b1;
      data_b   = rand_frame();
      run(260, 1'b0, 0);
      drv_mode = 0;

`ifdef GLOBAL_BRIGHTNESS_EN
      brightness = 8'h7F;
      req_a      = 1'b1;
      data_a     = 48'hFFFFFF_FF0080;
      run(120, 1'b0, 0);
      brightness = 8'hFF;
      req_b      = 1'b1;
      data_b     = 48'hFFFFFF_FF0080;
      run(120, 1'b0, 0);
`endif

      run(1500, 1'b0, 40);
      req_a      = 1'b0;
      req_b      = 1'b0;
      brightness = 8'hFF;
      run(60, 1'b0, 0);

      req_a  = 1'b1;
      data_a = rand_frame();
      s0     = n_starts;
      for (int k = 0; k < 300 && n_starts == s0; k++)
         run(1, 1'b0, 0);
      total++;
      if (n_starts == s0) begin
         bad++;
         $display("FAIL wait_start got=none want=drv_start within 300");
      end
      run(10, 1'b0, 0);
      #2;
      reset = 1'b1;
      #1;
      reset_checks("midrst");
      req_a  = 1'b1;
      req_b  = 1'b1;
      data_a = rand_frame();
      data_b = rand_frame();
      @(posedge clk);
      #2;
      reset = 1'b0;
      run(60, 1'b0, 0);
      req_a = 1'b0;
      req_b = 1'b0;
      run(20, 1'b0, 0);

      chk("q_ack_empty", 64'(qa.size()), 64'd0);
      chk("q_start_empty", 64'(qs.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
